// File: rtl/mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_div_unit : iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Optional feature macro: MDU_DIV_ZERO_FLAG_EN (adds sticky div_zero output).
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MDU_DIV_ZERO_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_op_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_b_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_accept;
   logic               w_mt_ok;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_iter;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_trial;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_mt_ok  = (r_state == S_IDLE) && !start;
   assign w_a_neg  = ~op[0] & rs_data[WIDTH-1];
   assign w_b_neg  = ~op[0] & rt_data[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -rs_data : rs_data;
   assign w_b_mag  = w_b_neg ? -rt_data : rt_data;
   // The counter runs one step past WIDTH so total busy time is WIDTH+2.
   assign w_iter   = (r_cnt < CNT_W'(WIDTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = op[1] ? S_DIV : S_MUL;
         S_MUL,
         S_DIV:   if (!w_iter) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Shift-add multiply: r_acc = {partial product, remaining multiplier bits}.
   assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   // Restoring divide: r_acc = {partial remainder, dividend/quotient bits}.
   assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

   always_comb begin
      w_step = r_acc;
      if (r_state == S_MUL) begin
         w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
      end else if (!w_div_trial[WIDTH]) begin
         w_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
   end

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_op_div) begin
         w_res_hi = w_rem;
         w_res_lo = r_b_zero ? '1 : w_quot;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_op_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_b_zero  <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIX);
         if (w_accept) begin
            r_cnt     <= '0;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_opnd    <= op[1] ? w_b_mag : w_a_mag;
            r_op_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (rt_data == '0);
         end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_iter) r_acc <= w_step;
         end else if (r_state == S_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
         if (w_mt_ok && mthi) r_hi <= wdata;
         if (w_mt_ok && mtlo) r_lo <= wdata;
      end
   end

`ifdef MDU_DIV_ZERO_FLAG_EN
   logic r_div_zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_zero <= 1'b0;
      end else if (w_accept || (w_mt_ok && (mthi || mtlo))) begin
         r_div_zero <= 1'b0;
      end else if ((r_state == S_FIX) && r_op_div && r_b_zero) begin
         r_div_zero <= 1'b1;
      end
   end

   assign div_zero = r_div_zero;
`endif

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_div_unit : scoreboard bench for mult_div_unit with a reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
   logic        div_zero;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
`ifdef MDU_DIV_ZERO_FLAG_EN
      ,
      .div_zero(div_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: {hi,lo} from plain 64-bit arithmetic on the architectural rules.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'd0;
      case (o)
         2'd0: p = 64'(sa * sb);
         2'd1: p = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFFFFFF};
            end else if (o == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end else begin
               p = {a % b, a / b};
            end
         end
      endcase
      return p;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         check("done_has_pending_op", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("result_hi_lo", {hi, lo}, mon_e);
         end
      end
   end

   // mode: 0 plain, 1 start+mthi pulsed mid-busy, 2 mtlo asserted alongside start
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
      logic [63:0] r;
      logic [31:0] h0, l0;
      int          n;
      bit          stable;
      r = model(o, a, b);
      @(negedge clk);
      check("done_low_when_idle", 64'(done), 64'd0);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      if (mode == 2) begin
         mtlo  = 1'b1;
         wdata = 32'h5555AAAA;
      end
      exp_q.push_back(r);
      h0 = hi;
      l0 = lo;
      @(negedge clk);
      start   = 1'b0;
      mtlo    = 1'b0;
      rs_data = $urandom;
      rt_data = $urandom;
      op      = 2'($urandom);
      n       = 0;
      stable  = 1'b1;
      while (busy === 1'b1 && n < 100) begin
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         n++;
         if (mode == 1 && n == 5) begin
            start = 1'b1;
            mthi  = 1'b1;
            wdata = 32'hDEADBEEF;
         end else begin
            start = 1'b0;
            mthi  = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      mthi  = 1'b0;
      check("busy_cycles", 64'(n), 64'd34);
      check("hilo_stable_while_busy", 64'(stable), 64'd1);
      check("done_pulse", 64'(done), 64'd1);
      {m_hi, m_lo} = r;
   endtask

   task automatic mt_write(input bit h, input bit l, input logic [31:0] d);
      @(negedge clk);
      mthi  = h;
      mtlo  = l;
      wdata = d;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      check("mt_hi", 64'(hi), 64'(m_hi));
      check("mt_lo", 64'(lo), 64'(m_lo));
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      op      = 2'd0;
      rs_data = 32'd0;
      rt_data = 32'd0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      wdata   = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
`ifdef MDU_DIV_ZERO_FLAG_EN
      check("reset_div_zero", 64'(div_zero), 64'd0);
`endif
      reset = 1'b1;

      run_op(2'd0, 32'hFFFFFFFF, 32'h00000002, 0);
      run_op(2'd1, 32'hFFFFFFFF, 32'h00000002, 0);
      run_op(2'd3, 32'd100, 32'd7, 0);
      run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 0);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(2'd3, 32'h12345678, 32'h00000000, 0);
`ifdef MDU_DIV_ZERO_FLAG_EN
      check("div_zero_set", 64'(div_zero), 64'd1);
      @(negedge clk);
      check("div_zero_held", 64'(div_zero), 64'd1);
`endif
      mt_write(1'b0, 1'b1, 32'h0BADF00D);
`ifdef MDU_DIV_ZERO_FLAG_EN
      check("div_zero_cleared", 64'(div_zero), 64'd0);
`endif
      run_op(2'd2, 32'h87654321, 32'h00000000, 0);
      run_op(2'd0, 32'h00001234, 32'hFFFF0001, 1);
      mt_write(1'b1, 1'b0, 32'hDEADBEEF);
      mt_write(1'b1, 1'b1, 32'hCAFEF00D);
      run_op(2'd1, 32'd7, 32'd9, 2);

      // Abort a DIVU mid-flight; any later done pulse is flagged by the monitor.
      @(negedge clk);
      start   = 1'b1;
      op      = 2'd3;
      rs_data = 32'd1000;
      rt_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("idle_after_abort", 64'(busy), 64'd0);
      run_op(2'd1, 32'd3, 32'd5, 0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op(2'($urandom), a, b, 0);
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("final_hi", 64'(hi), 64'(m_hi));
      check("final_lo", 64'(lo), 64'(m_lo));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
